sym_interp_fir_filter: RTL and testbench

Symmetric polyphase interpolating FIR for the transmit path: accepts one input sample per valid/ready handshake and emits UPSAMPLE filtered output samples through its own valid/ready handshake. It is the pulse-shaping counterpart of the receive-side symmetric FIR. Only half of the symmetric prototype is stored. It sits between the symbol mapper and the DAC-rate datapath.

---
 rtl/sym_interp_fir_filter.sv | 102 ++++++++++
 tb/tb_sym_interp_fir_filter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sym_interp_fir_filter.sv
// Symmetric polyphase interpolating FIR: one input sample yields UPSAMPLE outputs.
// Only half of the symmetric prototype is stored; the full tap table is mirrored at elaboration.
module sym_interp_fir_filter #(
   parameter int INPUT_WORD_SIZE = 16,
   parameter int COEFF_WORD_SIZE = 16,
   parameter int UPSAMPLE        = 4,
   parameter int TAPS_PER_PHASE  = 4,
   parameter logic [0:(UPSAMPLE*TAPS_PER_PHASE)/2-1][COEFF_WORD_SIZE-1:0] COEFFS = '0,
   localparam int OUTPUT_WORD_SIZE = INPUT_WORD_SIZE + COEFF_WORD_SIZE + $clog2(TAPS_PER_PHASE) + 1
) (
   input  logic                               clk,
   input  logic                               arst_n,
   input  logic signed [INPUT_WORD_SIZE-1:0]  data_in,
   input  logic                               valid_in,
   output logic                               ready_in,
   output logic signed [OUTPUT_WORD_SIZE-1:0] data_out,
   output logic                               valid_out,
   input  logic                               ready_out
);

   localparam int N      = UPSAMPLE * TAPS_PER_PHASE;
   localparam int HALF   = N / 2;
   localparam int PW     = $clog2(UPSAMPLE);
   localparam int PROD_W = INPUT_WORD_SIZE + COEFF_WORD_SIZE;
   localparam logic [PW-1:0] LAST_P = PW'(UPSAMPLE - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]                        state_q, state_d;
   logic [PW-1:0]                     p_q, p_d;
   logic signed [INPUT_WORD_SIZE-1:0] x_q [TAPS_PER_PHASE];
   logic signed [INPUT_WORD_SIZE-1:0] x_d [TAPS_PER_PHASE];

   logic signed [COEFF_WORD_SIZE-1:0]  ctab [TAPS_PER_PHASE][UPSAMPLE];
   logic signed [PROD_W-1:0]           prod;
   logic signed [OUTPUT_WORD_SIZE-1:0] acc;
   logic                               last_phase;
   logic                               accept;
   logic                               out_hs;

   // ctab[m][p] = h[p + m*L], with the upper half of h folded back onto the stored half
   for (genvar gm = 0; gm < TAPS_PER_PHASE; gm++) begin : g_tap
      for (genvar gp = 0; gp < UPSAMPLE; gp++) begin : g_ph
         localparam int IDX = gp + gm * UPSAMPLE;
         localparam int SRC = (IDX < HALF) ? IDX : (N - 1 - IDX);
         assign ctab[gm][gp] = COEFFS[SRC];
      end
   end

   always_comb begin
      acc  = '0;
      prod = '0;
      for (int m = 0; m < TAPS_PER_PHASE; m++) begin
         prod = PROD_W'(ctab[m][p_q]) * PROD_W'(x_q[m]);
         acc  = acc + OUTPUT_WORD_SIZE'(prod);
      end
   end

   assign valid_out  = (state_q == S_RUN);
   assign data_out   = valid_out ? acc : '0;
   assign last_phase = (p_q == LAST_P);
   assign ready_in   = (state_q == S_IDLE) | (last_phase & ready_out);
   assign accept     = valid_in & ready_in;
   assign out_hs     = valid_out & ready_out;

   // An accept on the last phase reloads directly, so a held valid_in gives back-to-back bursts
   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      x_d     = x_q;
      if (accept) begin
         for (int m = TAPS_PER_PHASE - 1; m > 0; m--) begin
            x_d[m] = x_q[m-1];
         end
         x_d[0]  = data_in;
         p_d     = '0;
         state_d = S_RUN;
      end else if (out_hs) begin
         if (!last_phase) begin
            p_d = p_q + 1'b1;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= S_IDLE;
         p_q     <= '0;
         for (int m = 0; m < TAPS_PER_PHASE; m++) begin
            x_q[m] <= '0;
         end
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         x_q     <= x_d;
      end
   end

endmodule

// File: tb/tb_sym_interp_fir_filter.sv
// Bench for sym_interp_fir_filter: three configurations share one stimulus stream and are
// each scored against a per-sample convolution model built from the full symmetric prototype.
module tb_sym_interp_fir_filter;

   localparam logic [0:1][15:0] CA = {16'sd1, 16'sd2};
   localparam logic [0:1][15:0] CB = {16'sd32767, 16'sd32767};
   localparam logic [0:7][15:0] CC = {16'sd32767, -16'sd32000, 16'sd1234, -16'sd5,
                                      16'sd0, 16'sd777, -16'sd31000, 16'sd20000};

   logic               clk = 1'b0;
   logic               arst_n;
   logic               valid_in;
   logic               ready_out;
   logic signed [15:0] data_in;

   logic signed [33:0] dout_a, dout_b;
   logic signed [34:0] dout_c;
   logic               vout_a, vout_b, vout_c;
   logic               rin_a, rin_b, rin_c;

   logic signed [63:0] dout [3];
   logic               vout [3];
   logic               rin  [3];

   int                 L [3];
   int                 T [3];
   longint             hfull [3][16];
   longint             hist  [3][16];
   longint             expq  [3][8];
   int                 ecnt  [3];
   logic signed [63:0] lg    [3][32];
   int                 lgn   [3];
   int                 imp_exp [6];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sym_interp_fir_filter #(.INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .UPSAMPLE(2),
                           .TAPS_PER_PHASE(2), .COEFFS(CA)) u_a (
      .clk(clk), .arst_n(arst_n), .data_in(data_in), .valid_in(valid_in), .ready_in(rin_a),
      .data_out(dout_a), .valid_out(vout_a), .ready_out(ready_out));

   sym_interp_fir_filter #(.INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .UPSAMPLE(2),
                           .TAPS_PER_PHASE(2), .COEFFS(CB)) u_b (
      .clk(clk), .arst_n(arst_n), .data_in(data_in), .valid_in(valid_in), .ready_in(rin_b),
      .data_out(dout_b), .valid_out(vout_b), .ready_out(ready_out));

   sym_interp_fir_filter #(.INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .UPSAMPLE(4),
                           .TAPS_PER_PHASE(4), .COEFFS(CC)) u_c (
      .clk(clk), .arst_n(arst_n), .data_in(data_in), .valid_in(valid_in), .ready_in(rin_c),
      .data_out(dout_c), .valid_out(vout_c), .ready_out(ready_out));

   assign dout[0] = 64'(dout_a);
   assign dout[1] = 64'(dout_b);
   assign dout[2] = 64'(dout_c);
   assign vout[0] = vout_a;
   assign vout[1] = vout_b;
   assign vout[2] = vout_c;
   assign rin[0]  = rin_a;
   assign rin[1]  = rin_b;
   assign rin[2]  = rin_c;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic clear_model();
      for (int id = 0; id < 3; id++) begin
         ecnt[id] = 0;
         for (int m = 0; m < 16; m++) hist[id][m] = 0;
      end
   endtask

   // One clock: check every DUT against the model, then advance the model by the handshakes it predicts.
   task automatic cycle();
      bit     pop [3];
      bit     acc [3];
      bit     ev, er;
      longint s;
      #1;
      for (int id = 0; id < 3; id++) begin
         ev = (ecnt[id] > 0);
         er = !ev || (ecnt[id] == 1 && ready_out);
         chk($sformatf("valid_out[%0d]", id), 64'(vout[id]), 64'(ev));
         chk($sformatf("data_out[%0d]", id), dout[id], ev ? 64'(expq[id][0]) : 64'sd0);
         chk($sformatf("ready_in[%0d]", id), 64'(rin[id]), 64'(er));
         pop[id] = ev && ready_out;
         acc[id] = valid_in && er;
      end
      for (int id = 0; id < 3; id++) begin
         if (pop[id]) begin
            if (lgn[id] < 32) begin
               lg[id][lgn[id]] = dout[id];
               lgn[id]++;
            end
            for (int k = 0; k < 7; k++) expq[id][k] = expq[id][k+1];
            ecnt[id]--;
         end
         if (acc[id]) begin
            for (int m = 15; m > 0; m--) hist[id][m] = hist[id][m-1];
            hist[id][0] = longint'(data_in);
            for (int p = 0; p < L[id]; p++) begin
               s = 0;
               for (int m = 0; m < T[id]; m++) s += hfull[id][p + m*L[id]] * hist[id][m];
               expq[id][ecnt[id]] = s;
               ecnt[id]++;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      valid_in = 1'b0;
      #3 arst_n = 1'b0;
      #1;
      for (int id = 0; id < 3; id++) begin
         chk($sformatf("rst_valid_out[%0d]", id), 64'(vout[id]), 64'sd0);
         chk($sformatf("rst_data_out[%0d]", id), dout[id], 64'sd0);
         chk($sformatf("rst_ready_in[%0d]", id), 64'(rin[id]), 64'sd1);
      end
      clear_model();
      @(negedge clk);
      arst_n = 1'b1;
   endtask

   // Offer one sample until the L=2 instances take it.
   task automatic send(input logic signed [15:0] v);
      bit r;
      valid_in = 1'b1;
      data_in  = v;
      for (int k = 0; k < 20; k++) begin
         r = (ecnt[0] == 0) || (ecnt[0] == 1 && ready_out);
         cycle();
         if (r) break;
      end
      valid_in = 1'b0;
   endtask

   task automatic drain();
      ready_out = 1'b1;
      valid_in  = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (ecnt[0] == 0 && ecnt[1] == 0 && ecnt[2] == 0) break;
         cycle();
      end
   endtask

   initial begin
      bit cr;
      L[0] = 2; T[0] = 2; L[1] = 2; T[1] = 2; L[2] = 4; T[2] = 4;
      for (int k = 0; k < 2; k++) begin
         hfull[0][k] = longint'($signed(CA[k])); hfull[0][3-k] = longint'($signed(CA[k]));
         hfull[1][k] = longint'($signed(CB[k])); hfull[1][3-k] = longint'($signed(CB[k]));
      end
      for (int k = 0; k < 8; k++) begin
         hfull[2][k] = longint'($signed(CC[k])); hfull[2][15-k] = longint'($signed(CC[k]));
      end
      imp_exp = '{1, 2, 2, 1, 0, 0};
      for (int id = 0; id < 3; id++) lgn[id] = 0;
      clear_model();
      arst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b0; data_in = '0;
      @(negedge clk);
      do_reset();

      // impulse on h = [1,2,2,1]
      ready_out = 1'b1;
      lgn[0] = 0;
      send(16'sd1); send(16'sd0); send(16'sd0);
      drain();
      for (int k = 0; k < 6; k++) chk($sformatf("impulse[%0d]", k), lg[0][k], 64'(imp_exp[k]));

      // backpressure during phase 0
      do_reset();
      ready_out = 1'b0; valid_in = 1'b1; data_in = 16'sd3;
      cycle();
      valid_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_hold_data", dout[0], 64'sd3);
         chk("bp_hold_valid", 64'(vout[0]), 64'sd1);
         chk("bp_ready_in", 64'(rin[0]), 64'sd0);
         cycle();
      end
      ready_out = 1'b1;
      lgn[0] = 0;
      cycle(); cycle();
      chk("bp_out0", lg[0][0], 64'sd3);
      chk("bp_out1", lg[0][1], 64'sd6);
      drain();

      // full-scale coefficients against most-negative input
      do_reset();
      ready_out = 1'b1;
      lgn[1] = 0;
      send(-16'sd32768); send(-16'sd32768); send(-16'sd32768);
      drain();
      chk("wide_first", lg[1][0], -64'sd1073709056);
      for (int k = 2; k < 6; k++) chk($sformatf("wide_steady[%0d]", k), lg[1][k], -64'sd2147418112);

      // reset while the L=4 instance sits on phase 1
      do_reset();
      ready_out = 1'b1; valid_in = 1'b1; data_in = 16'sd77;
      cycle();
      valid_in = 1'b0;
      cycle();
      do_reset();
      valid_in = 1'b1; data_in = 16'sd5;
      cycle();
      valid_in = 1'b0;
      lgn[2] = 0;
      drain();
      for (int k = 0; k < 4; k++) chk($sformatf("post_reset[%0d]", k), lg[2][k], 64'(5 * hfull[2][k]));

      // idle gap, history retained across it
      ready_out = 1'b1;
      for (int k = 0; k < 3; k++) send(16'($urandom));
      drain();
      for (int k = 0; k < 10; k++) begin
         #1;
         for (int id = 0; id < 3; id++) chk($sformatf("gap_valid[%0d]", id), 64'(vout[id]), 64'sd0);
         cycle();
      end
      send(16'sd1234);
      drain();

      // full rate: valid_in and ready_out held high
      ready_out = 1'b1; valid_in = 1'b1; data_in = 16'($urandom);
      for (int i = 0; i < 48; i++) begin
         #1;
         chk($sformatf("fr_ready_in[%0d]", i), 64'(rin[2]), 64'((i % 4) == 0));
         if (i > 0) chk($sformatf("fr_valid[%0d]", i), 64'(vout[2]), 64'sd1);
         cr = (ecnt[2] == 0) || (ecnt[2] == 1 && ready_out);
         cycle();
         if (cr) data_in = 16'($urandom);
      end
      drain();

      // random traffic on both handshakes
      for (int i = 0; i < 300; i++) begin
         valid_in  = 1'($urandom_range(0, 1));
         ready_out = ($urandom_range(0, 3) != 0);
         data_in   = 16'($urandom);
         cycle();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
